sys_ctrl: RTL

Command sequencer between the UART receive path and the register file, ALU and transmit FIFO. It consumes validated bytes from the UART receiver, decodes framed commands (register write, register read, ALU with operands, ALU without operands), drives the register-file and ALU control strobes, and queues response bytes into the TX FIFO. It runs in the reference (system) clock domain. `rx_valid_in` and `fifo_full_in` arrive already synchronised into this domain.

---
 rtl/sys_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sys_ctrl.sv
// sys_ctrl: decodes framed UART command bytes into register-file and ALU strobes,
// then pushes read or ALU response bytes into the TX FIFO.
module sys_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [DATA_WIDTH-1:0]   rx_data_in,
    input  logic                    rx_valid_in,
    input  logic [DATA_WIDTH-1:0]   rf_rd_data_in,
    input  logic                    rf_rd_valid_in,
    input  logic [2*DATA_WIDTH-1:0] alu_out_in,
    input  logic                    alu_valid_in,
    input  logic                    fifo_full_in,
    output logic [ADDR_WIDTH-1:0]   rf_addr_out,
    output logic                    rf_wr_en_out,
    output logic                    rf_rd_en_out,
    output logic [DATA_WIDTH-1:0]   rf_wr_data_out,
    output logic                    alu_en_out,
    output logic [FUN_WIDTH-1:0]    alu_fun_out,
    output logic                    clk_gate_en_out,
    output logic [DATA_WIDTH-1:0]   tx_data_out,
    output logic                    tx_wr_en_out,
    output logic [3:0]              state_dbg
);
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WR_ADDR  = 4'd1,
        WR_DATA  = 4'd2,
        RD_ADDR  = 4'd3,
        RD_WAIT  = 4'd4,
        OPA      = 4'd5,
        OPB      = 4'd6,
        ALU_FUN  = 4'd7,
        ALU_WAIT = 4'd8,
        SEND_RD  = 4'd9,
        SEND_LO  = 4'd10,
        SEND_HI  = 4'd11
    } state_t;

    localparam logic [DATA_WIDTH-1:0] OP_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OP_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] OP_ALU = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] OP_NOP = DATA_WIDTH'(8'hDD);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_nxt;
    logic [DATA_WIDTH-1:0]   rd_reg, rd_nxt;
    logic [2*DATA_WIDTH-1:0] res_reg, res_nxt;
    logic [FUN_WIDTH-1:0]    fun_reg, fun_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            addr_reg <= '0;
            rd_reg   <= '0;
            res_reg  <= '0;
            fun_reg  <= '0;
        end else begin
            state    <= state_nxt;
            addr_reg <= addr_nxt;
            rd_reg   <= rd_nxt;
            res_reg  <= res_nxt;
            fun_reg  <= fun_nxt;
        end
    end

    // Handshakes: a byte is consumed only in a cycle with rx_valid_in=1 in a state that
    // expects one; rf_rd_valid_in/alu_valid_in are accepted only in their wait state;
    // a TX byte is transferred exactly in a cycle with tx_wr_en_out=1 (FIFO not full).
    always_comb begin
        state_nxt       = state;
        addr_nxt        = addr_reg;
        rd_nxt          = rd_reg;
        res_nxt         = res_reg;
        fun_nxt         = fun_reg;
        rf_addr_out     = '0;
        rf_wr_en_out    = 1'b0;
        rf_rd_en_out    = 1'b0;
        rf_wr_data_out  = '0;
        alu_en_out      = 1'b0;
        alu_fun_out     = '0;
        clk_gate_en_out = 1'b0;
        tx_data_out     = '0;
        tx_wr_en_out    = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid_in) begin
                    if (rx_data_in == OP_WR)       state_nxt = WR_ADDR;
                    else if (rx_data_in == OP_RD)  state_nxt = RD_ADDR;
                    else if (rx_data_in == OP_ALU) state_nxt = OPA;
                    else if (rx_data_in == OP_NOP) state_nxt = ALU_FUN;
                end
            end
            WR_ADDR: begin
                if (rx_valid_in) begin
                    addr_nxt  = rx_data_in[ADDR_WIDTH-1:0];
                    state_nxt = WR_DATA;
                end
            end
            WR_DATA: begin
                if (rx_valid_in) begin
                    rf_wr_en_out   = 1'b1;
                    rf_addr_out    = addr_reg;
                    rf_wr_data_out = rx_data_in;
                    state_nxt      = IDLE;
                end
            end
            RD_ADDR: begin
                if (rx_valid_in) begin
                    rf_rd_en_out = 1'b1;
                    rf_addr_out  = rx_data_in[ADDR_WIDTH-1:0];
                    state_nxt    = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rf_rd_valid_in) begin
                    rd_nxt    = rf_rd_data_in;
                    state_nxt = SEND_RD;
                end
            end
            OPA, OPB: begin
                if (rx_valid_in) begin
                    rf_wr_en_out   = 1'b1;
                    rf_addr_out    = (state == OPA) ? ADDR_WIDTH'(0) : ADDR_WIDTH'(1);
                    rf_wr_data_out = rx_data_in;
                    state_nxt      = (state == OPA) ? OPB : ALU_FUN;
                end
            end
            ALU_FUN: begin
                clk_gate_en_out = 1'b1;
                if (rx_valid_in) begin
                    alu_en_out  = 1'b1;
                    alu_fun_out = rx_data_in[FUN_WIDTH-1:0];
                    fun_nxt     = rx_data_in[FUN_WIDTH-1:0];
                    state_nxt   = ALU_WAIT;
                end
            end
            ALU_WAIT: begin
                clk_gate_en_out = 1'b1;
                alu_en_out      = 1'b1;
                alu_fun_out     = fun_reg;
                if (alu_valid_in) begin
                    res_nxt   = alu_out_in;
                    state_nxt = SEND_LO;
                end
            end
            SEND_RD, SEND_LO, SEND_HI: begin
                tx_wr_en_out = !fifo_full_in;
                if (state == SEND_RD)      tx_data_out = rd_reg;
                else if (state == SEND_LO) tx_data_out = res_reg[DATA_WIDTH-1:0];
                else                       tx_data_out = res_reg[2*DATA_WIDTH-1:DATA_WIDTH];
                if (!fifo_full_in) state_nxt = (state == SEND_LO) ? SEND_HI : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign state_dbg = state;
endmodule
